// File: rtl/button_event_ctrl.sv
// Debounced button levels -> press/release/long/repeat events, arbitrated into a small FIFO.
// Define BUTTON_EVENT_REPEAT_EN to enable the auto-repeat path (HELD -> REPEAT).
module button_event_ctrl #(
    parameter int WIDTH        = 4,
    parameter int IDX_WIDTH    = 4,
    parameter int TICK_RATE    = 125000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in,
    output logic                 event_valid,
    input  logic                 event_ready,
    output logic [1:0]           event_type,
    output logic [IDX_WIDTH-1:0] event_index,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int PW = $clog2(TICK_RATE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_RATE - 1);
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [1:0] EV_REPEAT  = 2'd3;
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD, S_REPEAT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;
`endif

    logic [PW-1:0]           presc_q, presc_d;
    logic                    tick;
    logic [WIDTH-1:0]        in_reg_q;
    state_t                  state_q [WIDTH];
    state_t                  state_d [WIDTH];
    logic [15:0]             hold_q [WIDTH];
    logic [15:0]             hold_d [WIDTH];
    logic [WIDTH-1:0]        gen;
    logic [1:0]              gen_type [WIDTH];
    logic [WIDTH-1:0]        pend_vld_q, pend_vld_d;
    logic [1:0]              pend_type_q [WIDTH];
    logic [1:0]              pend_type_d [WIDTH];
    logic                    overflow_q, overflow_d;
    logic [IDX_WIDTH-1:0]    sel;
    logic                    any_pend, push, pop, full;
    logic [1+IDX_WIDTH:0]    fifo_wdata;
    logic [1+IDX_WIDTH:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;

    assign tick    = (presc_q == PRESC_MAX);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // Per-button hold FSM; a release takes priority over any tick that cycle.
    always_comb begin
        gen = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i]  = state_q[i];
            hold_d[i]   = hold_q[i];
            gen_type[i] = EV_PRESS;
            if (state_q[i] == S_IDLE) begin
                if (in[i] && !in_reg_q[i]) begin
                    state_d[i] = S_PRESSED;
                    hold_d[i]  = '0;
                    gen[i]     = 1'b1;
                end
            end else if (!in[i]) begin
                state_d[i]  = S_IDLE;
                hold_d[i]   = '0;
                gen[i]      = 1'b1;
                gen_type[i] = EV_RELEASE;
            end else if (tick) begin
                case (state_q[i])
                    S_PRESSED: begin
                        if (hold_q[i] == 16'(LONG_TICKS - 1)) begin
                            state_d[i]  = S_HELD;
                            hold_d[i]   = '0;
                            gen[i]      = 1'b1;
                            gen_type[i] = EV_LONG;
                        end else begin
                            hold_d[i] = hold_q[i] + 16'd1;
                        end
                    end
`ifdef BUTTON_EVENT_REPEAT_EN
                    S_HELD, S_REPEAT: begin
                        if (hold_q[i] == 16'(REPEAT_TICKS - 1)) begin
                            state_d[i]  = S_REPEAT;
                            hold_d[i]   = '0;
                            gen[i]      = 1'b1;
                            gen_type[i] = EV_REPEAT;
                        end else begin
                            hold_d[i] = hold_q[i] + 16'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // Lowest-index pending slot wins; a fresh load beats the drain of the same slot.
    always_comb begin
        sel      = '0;
        any_pend = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_vld_q[i]) begin
                sel      = IDX_WIDTH'(i);
                any_pend = 1'b1;
            end
        end
        full       = (count_q == (AW + 1)'(FIFO_DEPTH));
        pop        = event_valid && event_ready;
        push       = any_pend && (!full || pop);
        fifo_wdata = {pend_type_q[sel], sel};
        pend_vld_d = pend_vld_q;
        overflow_d = overflow_q;
        if (overflow_clr) overflow_d = 1'b0;
        if (push) pend_vld_d[sel] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            pend_type_d[i] = pend_type_q[i];
            if (gen[i]) begin
                if (pend_vld_q[i] && !(push && sel == IDX_WIDTH'(i))) overflow_d = 1'b1;
                pend_vld_d[i]  = 1'b1;
                pend_type_d[i] = gen_type[i];
            end
        end
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            in_reg_q   <= '0;
            pend_vld_q <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= S_IDLE;
                hold_q[i]  <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            in_reg_q   <= in;
            pend_vld_q <= pend_vld_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // Event payload storage; qualified by the valid bits above, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) pend_type_q[i] <= pend_type_d[i];
        if (push) fifo_mem[wr_ptr_q] <= fifo_wdata;
    end

    assign event_valid = (count_q != '0);
    assign event_type  = event_valid ? fifo_mem[rd_ptr_q][1+IDX_WIDTH:IDX_WIDTH] : 2'd0;
    assign event_index = event_valid ? fifo_mem[rd_ptr_q][IDX_WIDTH-1:0] : '0;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl with fast tick timing (TICK_RATE=4, LONG=3, REPEAT=2).
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_type;
    logic [3:0] event_index;
    logic       overflow;
    logic       overflow_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [5:0] sb [$];
    int         pop_cyc [$];
    logic [5:0] exp_ev;
    logic [5:0] held_val;
    bit         hold_prev = 1'b0;

    button_event_ctrl #(
        .WIDTH(4), .IDX_WIDTH(4), .TICK_RATE(4), .LONG_TICKS(3),
        .REPEAT_TICKS(2), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .event_valid(event_valid),
        .event_ready(event_ready), .event_type(event_type),
        .event_index(event_index), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    // Monitor: pops the scoreboard on every handshake and checks head stability under backpressure.
    always @(negedge clk) begin
        if (hold_prev) begin
            checks++;
            if ({event_type, event_index} !== held_val) begin
                errors++;
                $display("FAIL head_stable got %h required %h", {event_type, event_index}, held_val);
            end
        end
        if (!rst && event_valid && event_ready) begin
            checks++;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got type=%0d idx=%0d required none", event_type, event_index);
            end else begin
                exp_ev = sb.pop_front();
                if ({event_type, event_index} !== exp_ev) begin
                    errors++;
                    $display("FAIL event got type=%0d idx=%0d required type=%0d idx=%0d",
                             event_type, event_index, exp_ev[5:4], exp_ev[3:0]);
                end
            end
        end
        hold_prev = !rst && event_valid && !event_ready;
        held_val  = {event_type, event_index};
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !event_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bit ok;
        rst = 1'b1; in = 4'b0000; event_ready = 1'b0; overflow_clr = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if ({event_valid, event_type, event_index, overflow} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b required 00000000", {event_valid, event_type, event_index, overflow});
        end
        step(1);
        in = 4'b0100; event_ready = 1'b1;
        step(1);
        rst = 1'b0;
        sb.push_back({2'd0, 4'd2});
        @(posedge clk); @(negedge clk);
        checks++;
        if (event_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early event_valid got %b required 0", event_valid);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if ({event_valid, event_type, event_index} !== 7'b1_00_0010) begin
            errors++;
            $display("FAIL latency_press got %b required 1000010", {event_valid, event_type, event_index});
        end
        wait_drain(20, ok);
        in = 4'b0000;
        sb.push_back({2'd1, 4'd2});
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_drain pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_long_press;
        bit ok;
        int n_exp;
        pop_cyc.delete();
        event_ready = 1'b1;
        in = 4'b0001;
        sb.push_back({2'd0, 4'd0});
        sb.push_back({2'd2, 4'd0});
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat (3) sb.push_back({2'd3, 4'd0});
        n_exp = 6;
`else
        n_exp = 3;
`endif
        step(40);
        in = 4'b0000;
        sb.push_back({2'd1, 4'd0});
        wait_drain(60, ok);
        checks++;
        if (!ok || pop_cyc.size() != n_exp) begin
            errors++;
            $display("FAIL long_count got %0d events required %0d", pop_cyc.size(), n_exp);
        end else begin
            checks++;
            if (pop_cyc[1] - pop_cyc[0] < 9 || pop_cyc[1] - pop_cyc[0] > 12) begin
                errors++;
                $display("FAIL long_delay got %0d cycles required 9..12", pop_cyc[1] - pop_cyc[0]);
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            for (int k = 2; k < 5; k++) begin
                checks++;
                if (pop_cyc[k] - pop_cyc[k-1] != 8) begin
                    errors++;
                    $display("FAIL repeat_period got %0d cycles required 8", pop_cyc[k] - pop_cyc[k-1]);
                end
            end
`endif
            checks++;
            if (pop_cyc[n_exp-1] - pop_cyc[0] != 40) begin
                errors++;
                $display("FAIL release_time got %0d cycles required 40", pop_cyc[n_exp-1] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        pop_cyc.delete();
        event_ready = 1'b1;
        in = 4'b1011;
        sb.push_back({2'd0, 4'd0});
        sb.push_back({2'd0, 4'd1});
        sb.push_back({2'd0, 4'd3});
        wait_drain(20, ok);
        in = 4'b0000;
        sb.push_back({2'd1, 4'd0});
        sb.push_back({2'd1, 4'd1});
        sb.push_back({2'd1, 4'd3});
        wait_drain(20, ok);
        checks++;
        if (!ok || pop_cyc.size() != 6) begin
            errors++;
            $display("FAIL simul_count got %0d events required 6", pop_cyc.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (pop_cyc[k] - pop_cyc[k-1] != 1) begin
                    errors++;
                    $display("FAIL simul_spacing got %0d cycles required 1", pop_cyc[k] - pop_cyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        bit ok;
        event_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            in[1] = ~in[1];
            if (k != 8) sb.push_back({(k % 2 == 0) ? 2'd0 : 2'd1, 4'd1});
            step(2);
            if (k == 8) begin
                @(negedge clk);
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL overflow_early got %b required 0", overflow);
                end
                step(1);
            end
        end
        step(3);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got %b required 1", overflow);
        end
        step(1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b required 0", overflow);
        end
        step(1);
        event_ready = 1'b1;
        wait_drain(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL overflow_drain pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        event_ready = 1'b0;
        in = 4'b0111;
        for (int k = 0; k < 3; k++) sb.push_back({2'd0, 4'(k)});
        step(5);
        in = 4'b0000;
        for (int k = 0; k < 3; k++) sb.push_back({2'd1, 4'(k)});
        step(4);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            event_ready = ~event_ready;
            step(1);
            if (sb.size() == 0 && !event_valid) begin
                ok = 1'b1;
                break;
            end
        end
        event_ready = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL toggle_drain pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        event_ready = 1'b0;
        in = 4'b0111;
        step(6);
        @(negedge clk);
        checks++;
        if (event_valid !== 1'b1) begin
            errors++;
            $display("FAIL queued_before_reset event_valid got %b required 1", event_valid);
        end
        step(1);
        rst = 1'b1;
        sb.delete();
        step(1);
        rst = 1'b0;
        event_ready = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back({2'd0, 4'(k)});
        @(negedge clk);
        checks++;
        if ({event_valid, overflow, event_type, event_index} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid got %b required 00000000", {event_valid, overflow, event_type, event_index});
        end
        wait_drain(20, ok);
        in = 4'b0000;
        for (int k = 0; k < 3; k++) sb.push_back({2'd1, 4'(k)});
        wait_drain(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_mid_drain pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_long_press();
        test_simultaneous();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        step(10);
        @(negedge clk);
        checks++;
        if (event_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL final_idle event_valid=%b pending=%0d required 0 and 0", event_valid, sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
